stim_hbridge_driver: RTL

STIM_HBRIDGE_DRIVER -- requirements
Module: stim_hbridge_driver

---
 rtl/stim_hbridge_driver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stim_hbridge_driver.sv
// H-bridge switch sequencer for a stimulator output stage: break-before-make dead time,
// current-source lead on leaving idle, and a level-sensitive fault that forces a safe short.
//   state | meaning
//   SHORT | both bottom switches closed, electrode shorted, current source off
//   BREAK | all switches open for DT_CYCLES clocks before any closure
//   LEAD  | switches open, current source enabled ahead of closure
//   DRIVE | anodic or cathodic diagonal closed, current source on
module stim_hbridge_driver #(
  parameter int unsigned DT_CYCLES = 4,
  parameter int unsigned ENA_LEAD  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_phase_req,
  input  logic       i_phase_vld,
  output logic       o_phase_rdy,
  input  logic       i_fault,
  output logic       o_ano_top,
  output logic       o_ano_bot,
  output logic       o_cat_top,
  output logic       o_cat_bot,
  output logic       o_curr_ena,
  output logic       o_busy,
  output logic       o_err,
  output logic       o_fault_seen
);

  typedef enum logic [1:0] {ST_SHORT, ST_BREAK, ST_LEAD, ST_DRIVE} state_t;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_ANO  = 2'b01;
  localparam logic [1:0] PH_CAT  = 2'b10;
  localparam logic [1:0] PH_BAD  = 2'b11;
  localparam logic [7:0] DT_LD   = 8'(DT_CYCLES);
  localparam logic [7:0] LEAD_LD = 8'(ENA_LEAD);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] tgt_q, tgt_d;
  logic       from_drv_q, from_drv_d;
  logic       err_q, err_d;
  logic       fseen_q, fseen_d;
  logic [3:0] sw_q, sw_d;   // {ano_top, ano_bot, cat_top, cat_bot}
  logic       ena_q, ena_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;

  logic       accept;
  logic [1:0] req_ph;

  always_comb begin
    accept     = i_phase_vld && rdy_q && !i_fault;
    req_ph     = (i_phase_req == PH_BAD) ? PH_IDLE : i_phase_req;
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    from_drv_d = from_drv_q;
    err_d      = err_q;
    fseen_d    = fseen_q;

    if (i_fault) begin
      // Reloading every faulted edge makes the dead time count from the last faulted sample.
      state_d    = ST_BREAK;
      cnt_d      = DT_LD;
      tgt_d      = PH_IDLE;
      from_drv_d = 1'b0;
      fseen_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_SHORT: begin
          if (accept) begin
            if (i_phase_req == PH_BAD) err_d = 1'b1;
            if (req_ph != PH_IDLE) begin
              state_d    = ST_BREAK;
              cnt_d      = DT_LD;
              tgt_d      = req_ph;
              from_drv_d = 1'b0;
            end
          end
        end
        ST_DRIVE: begin
          if (accept) begin
            if (i_phase_req == PH_BAD) err_d = 1'b1;
            if (req_ph != tgt_q) begin
              state_d    = ST_BREAK;
              cnt_d      = DT_LD;
              tgt_d      = req_ph;
              from_drv_d = 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (cnt_q <= 8'd1) begin
            if (tgt_q == PH_IDLE) begin
              state_d = ST_SHORT;
            end else if (from_drv_q || (LEAD_LD == 8'd0)) begin
              state_d = ST_DRIVE;
            end else begin
              state_d = ST_LEAD;
              cnt_d   = LEAD_LD;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_LEAD: begin
          if (cnt_q <= 8'd1) state_d = ST_DRIVE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        default: begin
          state_d = ST_BREAK;
          cnt_d   = DT_LD;
          tgt_d   = PH_IDLE;
        end
      endcase
    end

    sw_d  = 4'b0000;
    ena_d = 1'b0;
    unique case (state_d)
      ST_SHORT: sw_d = 4'b0101;
      ST_BREAK: ena_d = from_drv_d && (tgt_d != PH_IDLE);
      ST_LEAD:  ena_d = 1'b1;
      ST_DRIVE: begin
        ena_d = 1'b1;
        if (tgt_d == PH_ANO)      sw_d = 4'b1001;
        else if (tgt_d == PH_CAT) sw_d = 4'b0110;
      end
      default: ;
    endcase
    rdy_d  = (state_d == ST_SHORT) || (state_d == ST_DRIVE);
    busy_d = !rdy_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_BREAK;
      cnt_q      <= DT_LD;
      tgt_q      <= PH_IDLE;
      from_drv_q <= 1'b0;
      err_q      <= 1'b0;
      fseen_q    <= 1'b0;
      sw_q       <= 4'b0000;
      ena_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      from_drv_q <= from_drv_d;
      err_q      <= err_d;
      fseen_q    <= fseen_d;
      sw_q       <= sw_d;
      ena_q      <= ena_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ano_top    = sw_q[3];
  assign o_ano_bot    = sw_q[2];
  assign o_cat_top    = sw_q[1];
  assign o_cat_bot    = sw_q[0];
  assign o_curr_ena   = ena_q;
  assign o_phase_rdy  = rdy_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;
  assign o_fault_seen = fseen_q;

endmodule
